// File: rtl/ttm4_prog_loader.sv
// Byte-stream program loader for the TTM4 CPU: parses framed LO/HI word pairs,
// writes them to program memory and releases CPU reset only on a good checksum.
module ttm4_prog_loader #(
  parameter logic [7:0] START_BYTE = 8'hA5,
  parameter int         ADDR_W     = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [7:0]        RX_DATA,
  input  logic              RX_VALID,
  output logic              RX_READY,
  output logic              WR_EN,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [14:0]       WR_DATA,
  output logic              CPU_RST,
  output logic              DONE,
  output logic              ERR
);

  // state   | meaning
  // IDLE    | waiting for START_BYTE, other bytes dropped
  // COUNT   | next byte is the word count N (0 = 256)
  // LO      | next byte is instr[7:0]
  // HI      | next byte is instr[14:8], bit 7 must be clear
  // WRITE   | one-cycle memory write, no byte consumed
  // CHK     | next byte is the XOR checksum
  typedef enum logic [2:0] {S_IDLE, S_COUNT, S_LO, S_HI, S_WRITE, S_CHK} state_t;

  state_t            state_q, state_d;
  logic [8:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        lo_q, lo_d;
  logic [7:0]        ck_q, ck_d;
  logic [14:0]       wr_data_q, wr_data_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              rx_fire;

  assign RX_READY = !RST && (state_q != S_WRITE);
  assign rx_fire  = RX_VALID && RX_READY;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    lo_d      = lo_q;
    ck_d      = ck_q;
    wr_data_d = wr_data_q;
    cpu_rst_d = cpu_rst_q;
    done_d    = done_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        if (rx_fire && (RX_DATA == START_BYTE)) begin
          state_d   = S_COUNT;
          cpu_rst_d = 1'b1;
          done_d    = 1'b0;
          err_d     = 1'b0;
          addr_d    = '0;
          ck_d      = 8'h00;
        end
      end
      S_COUNT: begin
        if (rx_fire) begin
          cnt_d   = (RX_DATA == 8'h00) ? 9'd256 : {1'b0, RX_DATA};
          ck_d    = ck_q ^ RX_DATA;
          state_d = S_LO;
        end
      end
      S_LO: begin
        if (rx_fire) begin
          lo_d    = RX_DATA;
          ck_d    = ck_q ^ RX_DATA;
          state_d = S_HI;
        end
      end
      S_HI: begin
        if (rx_fire) begin
          if (RX_DATA[7]) begin
            // Abort without writing; CPU stays held in reset
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            ck_d      = ck_q ^ RX_DATA;
            wr_data_d = {RX_DATA[6:0], lo_q};
            state_d   = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        addr_d  = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        cnt_d   = cnt_q - 9'd1;
        state_d = (cnt_q == 9'd1) ? S_CHK : S_LO;
      end
      S_CHK: begin
        if (rx_fire) begin
          if (RX_DATA == ck_q) begin
            done_d    = 1'b1;
            cpu_rst_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= 9'd0;
      addr_q    <= '0;
      lo_q      <= 8'h00;
      ck_q      <= 8'h00;
      wr_data_q <= 15'h0000;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      lo_q      <= lo_d;
      ck_q      <= ck_d;
      wr_data_q <= wr_data_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign WR_EN   = (state_q == S_WRITE);
  assign WR_ADDR = addr_q;
  assign WR_DATA = wr_data_q;
  assign CPU_RST = cpu_rst_q;
  assign DONE    = done_q;
  assign ERR     = err_q;

endmodule

// File: tb/tb_ttm4_prog_loader.sv
// Bench for ttm4_prog_loader: frame-level reference model with an expected-write
// queue and flag expectations, checked every cycle by one compare process.
module tb_ttm4_prog_loader;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  RX_DATA = 8'h00;
  logic        RX_VALID = 1'b0;
  logic        RX_READY;
  logic        WR_EN;
  logic [7:0]  WR_ADDR;
  logic [14:0] WR_DATA;
  logic        CPU_RST;
  logic        DONE;
  logic        ERR;

  ttm4_prog_loader #(.START_BYTE(8'hA5), .ADDR_W(8)) dut (
    .CLK(CLK), .RST(RST), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_READY(RX_READY),
    .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .CPU_RST(CPU_RST),
    .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  logic [14:0] words [256];
  logic [7:0]  qa [$];
  logic [14:0] qd [$];
  bit          flags_valid = 1'b0;
  bit          exp_done = 1'b0;
  bit          exp_err = 1'b0;
  bit          exp_cpu = 1'b1;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model
  always @(negedge CLK) begin
    if (!RST) begin
      chk(RX_READY == !WR_EN, "rx_ready_vs_write", {31'd0, RX_READY}, {31'd0, !WR_EN});
      if (WR_EN) begin
        if (qa.size() == 0) begin
          chk(1'b0, "unexpected_wr", {24'd0, WR_ADDR}, 32'd0);
        end else begin
          chk(WR_ADDR == qa[0], "wr_addr", {24'd0, WR_ADDR}, {24'd0, qa[0]});
          chk(WR_DATA == qd[0], "wr_data", {17'd0, WR_DATA}, {17'd0, qd[0]});
          void'(qa.pop_front());
          void'(qd.pop_front());
        end
      end
      if (flags_valid) begin
        chk(DONE == exp_done, "done", {31'd0, DONE}, {31'd0, exp_done});
        chk(ERR == exp_err, "err", {31'd0, ERR}, {31'd0, exp_err});
        chk(CPU_RST == exp_cpu, "cpu_rst", {31'd0, CPU_RST}, {31'd0, exp_cpu});
      end
    end
  end

  function automatic logic [7:0] frame_ck(input int nw);
    logic [7:0] x;
    logic [7:0] nb;
    nb = nw[7:0];
    x = nb;
    for (int i = 0; i < nw; i++) x = x ^ words[i][7:0] ^ {1'b0, words[i][14:8]};
    return x;
  endfunction

  // Called and returns just after a negedge; gap<0 picks a random gap per byte.
  task automatic send_byte(input logic [7:0] b, input int gap, output time t_acc);
    bit acc;
    int g;
    acc = 1'b0;
    t_acc = 0;
    RX_DATA = b;
    RX_VALID = 1'b1;
    for (int k = 0; k < 8 && !acc; k++) begin
      if (RX_READY) begin
        @(posedge CLK);
        t_acc = $time;
        acc = 1'b1;
      end
      @(negedge CLK);
    end
    if (!acc) chk(1'b0, "rx_timeout", {24'd0, b}, 32'd1);
    g = (gap < 0) ? int'($urandom_range(0, 1)) : gap;
    if (g > 0) begin
      RX_VALID = 1'b0;
      repeat (g) @(negedge CLK);
    end
  endtask

  task automatic send_frame(input int n, input int bad_idx, input bit bad_ck, input int gap,
                            output time t_first, output time t_last);
    int nw;
    int lim;
    logic [7:0] ck;
    logic [7:0] nb;
    time t;
    nw = (n == 0) ? 256 : n;
    nb = n[7:0];
    lim = (bad_idx >= 0) ? bad_idx : nw;
    ck = frame_ck(nw);
    if (bad_ck) ck = ~ck;
    flags_valid = 1'b0;
    for (int i = 0; i < lim; i++) begin
      qa.push_back(i[7:0]);
      qd.push_back(words[i]);
    end
    send_byte(8'hA5, gap, t_first);
    send_byte(nb, gap, t);
    t_last = t;
    for (int i = 0; i < nw; i++) begin
      send_byte(words[i][7:0], gap, t);
      if (i == bad_idx) begin
        send_byte(8'h80 | {1'b0, words[i][14:8]}, gap, t);
        break;
      end
      send_byte({1'b0, words[i][14:8]}, gap, t);
    end
    if (bad_idx < 0) send_byte(ck, gap, t_last);
    RX_VALID = 1'b0;
    repeat (2) @(negedge CLK);
    exp_done = (bad_idx < 0) && !bad_ck;
    exp_err = !exp_done;
    exp_cpu = !exp_done;
    chk(qa.size() == 0, "writes_missing", qa.size(), 32'd0);
    chk(WR_ADDR == lim[7:0], "end_addr", {24'd0, WR_ADDR}, {24'd0, lim[7:0]});
    chk(DONE == exp_done && ERR == exp_err && CPU_RST == exp_cpu, "end_flags",
        {29'd0, DONE, ERR, CPU_RST}, {29'd0, exp_done, exp_err, exp_cpu});
    flags_valid = 1'b1;
  endtask

  task automatic check_reset_values(input string tag);
    chk(RX_READY == 1'b0, {tag, "_rx_ready"}, {31'd0, RX_READY}, 32'd0);
    chk(WR_EN == 1'b0, {tag, "_wr_en"}, {31'd0, WR_EN}, 32'd0);
    chk(WR_ADDR == 8'd0, {tag, "_wr_addr"}, {24'd0, WR_ADDR}, 32'd0);
    chk(WR_DATA == 15'd0, {tag, "_wr_data"}, {17'd0, WR_DATA}, 32'd0);
    chk(CPU_RST == 1'b1, {tag, "_cpu_rst"}, {31'd0, CPU_RST}, 32'd1);
    chk(DONE == 1'b0, {tag, "_done"}, {31'd0, DONE}, 32'd0);
    chk(ERR == 1'b0, {tag, "_err"}, {31'd0, ERR}, 32'd0);
  endtask

  task automatic send_garbage();
    time t;
    send_byte(8'h00, 0, t);
    send_byte(8'hFF, 0, t);
    send_byte(8'h5A, 0, t);
    RX_VALID = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    time t0, t1, t;
    int n, bad_idx;
    bit bad_ck;

    repeat (3) @(negedge CLK);
    check_reset_values("por");
    RST = 1'b0;
    exp_done = 1'b0; exp_err = 1'b0; exp_cpu = 1'b1;
    flags_valid = 1'b1;
    @(negedge CLK);

    // Garbage in IDLE after reset
    send_garbage();
    chk(WR_ADDR == 8'd0 && CPU_RST == 1'b1, "garbage_idle", {23'd0, CPU_RST, WR_ADDR}, 32'h100);

    // Two-word frame; checksum per the XOR rule is 0xA4
    words[0] = 15'h1234;
    words[1] = 15'h7FFF;
    chk(frame_ck(2) == 8'hA4, "model_ck_pin", {24'd0, frame_ck(2)}, 32'hA4);
    send_frame(2, -1, 1'b0, 0, t0, t1);
    chk(DONE && !CPU_RST && !ERR, "basic_done", {29'd0, DONE, ERR, CPU_RST}, 32'h4);
    chk((t1 - t0) == 80, "full_speed_timing", t1 - t0, 32'd80);

    // Garbage after a good load leaves DONE held
    send_garbage();

    send_frame(2, -1, 1'b1, 0, t0, t1);
    chk(ERR && !DONE && CPU_RST, "bad_ck", {29'd0, DONE, ERR, CPU_RST}, 32'h3);

    // Bad HI in first pair, then restart
    send_frame(2, 0, 1'b0, 0, t0, t1);
    chk(ERR && !DONE && CPU_RST, "bad_hi", {29'd0, DONE, ERR, CPU_RST}, 32'h3);
    send_byte(8'hA5, 0, t);
    RX_VALID = 1'b0;
    flags_valid = 1'b0;
    @(negedge CLK);
    chk(!ERR && !DONE && CPU_RST, "restart_clears", {29'd0, DONE, ERR, CPU_RST}, 32'h1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    for (int i = 0; i < 3; i++) words[i] = 15'($urandom);
    send_frame(3, -1, 1'b0, 0, t0, t1);

    // RX_VALID toggling every other cycle
    for (int i = 0; i < 5; i++) words[i] = 15'($urandom);
    send_frame(5, -1, 1'b0, 1, t0, t1);

    // N=0 loads 256 words, data = address
    for (int i = 0; i < 256; i++) words[i] = 15'(i);
    send_frame(0, -1, 1'b0, 0, t0, t1);
    chk(DONE && WR_ADDR == 8'd0, "n0_wrap_done", {23'd0, DONE, WR_ADDR}, 32'h100);

    // Reset between LO and HI of word 3
    for (int i = 0; i < 4; i++) words[i] = 15'($urandom);
    flags_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      qa.push_back(i[7:0]);
      qd.push_back(words[i]);
    end
    send_byte(8'hA5, 0, t);
    send_byte(8'h04, 0, t);
    for (int i = 0; i < 2; i++) begin
      send_byte(words[i][7:0], 0, t);
      send_byte({1'b0, words[i][14:8]}, 0, t);
    end
    send_byte(words[2][7:0], 0, t);
    RX_VALID = 1'b0;
    chk(qa.size() == 0, "pre_reset_writes", qa.size(), 32'd0);
    #2 RST = 1'b1;
    #1 check_reset_values("midrst");
    @(negedge CLK);
    RST = 1'b0;
    exp_done = 1'b0; exp_err = 1'b0; exp_cpu = 1'b1;
    flags_valid = 1'b1;
    @(negedge CLK);
    for (int i = 0; i < 3; i++) words[i] = 15'($urandom);
    send_frame(3, -1, 1'b0, 0, t0, t1);

    // Randomized frames
    for (int f = 0; f < 20; f++) begin
      n = int'($urandom_range(1, 9));
      for (int i = 0; i < n; i++) words[i] = 15'($urandom);
      bad_idx = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      bad_ck = ($urandom_range(0, 3) == 0);
      send_frame(n, bad_idx, bad_ck, -1, t0, t1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0t expected=finish", $time);
    $fatal(1, "timeout");
  end

endmodule
